// File: rtl/aes444_pkg.sv
// Shared types, constants and PRNG helpers for the AES444 share driver.
package aes444_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    RESP
  } state_t;

  // Right-shifting Galois LFSR64 feedback taps.
  localparam logic [63:0] LFSR_TAP   = 64'hD800_0000_0000_0000;
  // Golden-ratio constant used to decorrelate the lane seeds.
  localparam logic [63:0] GOLDEN     = 64'h9E37_79B9_7F4A_7C15;
  localparam int          RAND_W     = 360;
  localparam int          PRNG_LANES = 8;

  // One Galois shift of a 64-bit lane.
  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return {1'b0, s[63:1]} ^ (s[0] ? LFSR_TAP : 64'h0);
  endfunction

  // Per-lane seed; an all-zero lane would lock up, so it is forced to 1.
  function automatic logic [63:0] lane_seed(input logic [63:0] seed, input int lane);
    logic [63:0] v;
    v = seed ^ (64'(lane) * GOLDEN);
    return (v == 64'h0) ? 64'h1 : v;
  endfunction

endpackage

// File: rtl/dom_prng.sv
// Eight parallel Galois LFSR64 lanes. rnd_out shows the value the lanes
// take after one step from either the current state or, when seed_load is
// high, from the freshly seeded state, so a caller can register a draw on
// the same edge that advances the generator.
module dom_prng
  import aes444_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       seed_load,
  input  logic [63:0]                seed,
  input  logic                       step,
  output logic [PRNG_LANES*64-1:0]   rnd_out
);

  for (genvar gi = 0; gi < PRNG_LANES; gi++) begin : g_lane
    logic [63:0] lane_reg;
    logic [63:0] lane_base;
    logic [63:0] lane_stepped;

    // Seed takes priority over the stored state so a same-cycle draw uses the new seed.
    always_comb begin
      lane_base    = seed_load ? lane_seed(seed, gi) : lane_reg;
      lane_stepped = lfsr_step(lane_base);
    end

    assign rnd_out[gi*64 +: 64] = lane_stepped;

    // Lane state: default seed after reset, then load and/or advance on request.
    always_ff @(posedge clk) begin
      if (rst) begin
        lane_reg <= lane_seed(64'h1, gi);
      end else if (step) begin
        lane_reg <= lane_stepped;
      end else if (seed_load) begin
        lane_reg <= lane_base;
      end
    end
  end

endmodule

// File: rtl/aes444_share_driver.sv
// Initiator for one AES444 core: masks a key/plaintext request into two
// shares, pulses start, refreshes randomness once per round, captures the
// ciphertext after the fixed core latency and hands it back on a
// valid/ready response.
module aes444_share_driver
  import aes444_pkg::*;
#(
  parameter int ROUNDS      = 10,
  parameter int CYC_PER_RND = 4,
  parameter int SETUP       = 2,
  parameter int LATENCY     = 42,
  parameter bit MASK_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_load,
  input  logic [63:0]       seed,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [63:0]       req_key,
  input  logic [63:0]       req_text,
  output logic              aes_start,
  output logic [63:0]       aes_key_in,
  output logic [63:0]       aes_k_mask,
  output logic [63:0]       aes_text_in,
  output logic [63:0]       aes_t_mask,
  output logic [RAND_W-1:0] aes_random_bits,
  input  logic [63:0]       aes_text_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_text
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int PH_W  = (CYC_PER_RND > 1) ? $clog2(CYC_PER_RND) : 1;
  localparam int SU_W  = (SETUP > 1) ? $clog2(SETUP) : 1;
  localparam int RC_W  = $clog2(ROUNDS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CYC_PER_RND - 1);
  localparam logic [SU_W-1:0]  SU_LAST  = SU_W'(SETUP - 1);
  localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(ROUNDS);

  // All randomness refreshes must land before the ciphertext is captured.
  if (LATENCY < ROUNDS * CYC_PER_RND || ROUNDS < 1 || SETUP < 1 || CYC_PER_RND < 1) begin : g_param_check
    $error("aes444_share_driver: LATENCY must cover ROUNDS*CYC_PER_RND and all counts must be >= 1");
  end

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [PH_W-1:0]  phase_reg;
  logic [SU_W-1:0]  setup_cnt_reg;
  logic [RC_W-1:0]  rnd_cnt_reg;

  logic [PRNG_LANES*64-1:0] prng_out;
  logic                     prng_unused;
  logic                     accept;
  logic                     reload;
  logic                     prng_seed_load;
  logic [63:0]              k_mask_draw;
  logic [63:0]              t_mask_draw;
  logic [RAND_W-1:0]        rand_draw;

  assign req_ready      = (state_reg == IDLE);
  assign accept         = req_valid && (state_reg == IDLE);
  assign prng_seed_load = seed_load && (state_reg == IDLE);
  // First refresh on the start cycle, then once per round until ROUNDS are issued.
  assign reload = (state_reg == START) ||
                  ((state_reg == RUN) && (phase_reg == PH_LAST) && (rnd_cnt_reg < RC_MAX));

  assign k_mask_draw = MASK_EN ? prng_out[63:0]   : 64'h0;
  assign t_mask_draw = MASK_EN ? prng_out[127:64] : 64'h0;
  assign rand_draw   = prng_out[128 +: RAND_W];
  assign prng_unused = ^prng_out[PRNG_LANES*64-1:128+RAND_W];

  dom_prng u_prng (
    .clk       (clk),
    .rst       (rst),
    .seed_load (prng_seed_load),
    .seed      (seed),
    .step      (accept || reload),
    .rnd_out   (prng_out)
  );

  // Sequencer: request capture, setup hold, start pulse, round timing, response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      phase_reg       <= '0;
      setup_cnt_reg   <= '0;
      rnd_cnt_reg     <= '0;
      aes_start       <= 1'b0;
      aes_key_in      <= '0;
      aes_k_mask      <= '0;
      aes_text_in     <= '0;
      aes_t_mask      <= '0;
      aes_random_bits <= '0;
      rsp_valid       <= 1'b0;
      rsp_text        <= '0;
    end else begin
      aes_start <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            aes_key_in      <= req_key ^ k_mask_draw;
            aes_k_mask      <= k_mask_draw;
            aes_text_in     <= req_text ^ t_mask_draw;
            aes_t_mask      <= t_mask_draw;
            aes_random_bits <= rand_draw;
            setup_cnt_reg   <= '0;
            state_reg       <= LOAD;
          end
        end
        LOAD: begin
          if (setup_cnt_reg == SU_LAST) begin
            aes_start <= 1'b1;
            state_reg <= START;
          end else begin
            setup_cnt_reg <= setup_cnt_reg + 1'b1;
          end
        end
        START: begin
          aes_random_bits <= rand_draw;
          cnt_reg         <= '0;
          phase_reg       <= '0;
          rnd_cnt_reg     <= RC_W'(1);
          state_reg       <= RUN;
        end
        RUN: begin
          cnt_reg   <= cnt_reg + 1'b1;
          phase_reg <= (phase_reg == PH_LAST) ? '0 : phase_reg + 1'b1;
          if (reload) begin
            aes_random_bits <= rand_draw;
            rnd_cnt_reg     <= rnd_cnt_reg + 1'b1;
          end
          if (cnt_reg == CNT_LAST) begin
            rsp_text  <= aes_text_out;
            rsp_valid <= 1'b1;
            state_reg <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid       <= 1'b0;
            rsp_text        <= '0;
            aes_key_in      <= '0;
            aes_k_mask      <= '0;
            aes_text_in     <= '0;
            aes_t_mask      <= '0;
            aes_random_bits <= '0;
            state_reg       <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes444_share_driver.sv
// Directed bench with a response scoreboard for aes444_share_driver.
module tb_aes444_share_driver;

  localparam int          LATENCY = 42;
  localparam logic [63:0] CT      = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] K1      = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] K2      = 64'h1111_2222_3333_4444;
  localparam logic [63:0] T2      = 64'h5555_6666_7777_8888;
  localparam logic [63:0] K3      = 64'h0F0F_1E1E_2D2D_3C3C;
  localparam logic [63:0] T3      = 64'hC3C3_B4B4_A5A5_9696;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         seed_load = 1'b0;
  logic [63:0]  seed = '0;
  logic         req_valid = 1'b0;
  logic [63:0]  req_key = '0;
  logic [63:0]  req_text = '0;
  logic         rsp_ready = 1'b1;
  logic [63:0]  aes_text_out;

  logic         req_ready, aes_start, rsp_valid;
  logic [63:0]  aes_key_in, aes_k_mask, aes_text_in, aes_t_mask, rsp_text;
  logic [359:0] aes_random_bits;

  logic         d_req_ready, d_aes_start, d_rsp_valid;
  logic [63:0]  d_aes_key_in, d_aes_k_mask, d_aes_text_in, d_aes_t_mask, d_rsp_text;
  logic [359:0] d_aes_random_bits;

  int checks = 0;
  int failures = 0;
  logic [63:0]  exp_q[$];
  logic [359:0] rnd_log[10];
  logic [359:0] ref_log[10];
  logic [63:0]  last_k, last_t, ref_t;
  int core_cnt;

  aes444_share_driver #(.ROUNDS(10), .CYC_PER_RND(4), .SETUP(2), .LATENCY(LATENCY), .MASK_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_text(req_text),
    .aes_start(aes_start), .aes_key_in(aes_key_in), .aes_k_mask(aes_k_mask),
    .aes_text_in(aes_text_in), .aes_t_mask(aes_t_mask), .aes_random_bits(aes_random_bits),
    .aes_text_out(aes_text_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_text(rsp_text)
  );

  aes444_share_driver #(.ROUNDS(10), .CYC_PER_RND(4), .SETUP(2), .LATENCY(LATENCY), .MASK_EN(1'b0)) u_dbg (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .req_valid(req_valid), .req_ready(d_req_ready), .req_key(req_key), .req_text(req_text),
    .aes_start(d_aes_start), .aes_key_in(d_aes_key_in), .aes_k_mask(d_aes_k_mask),
    .aes_text_in(d_aes_text_in), .aes_t_mask(d_aes_t_mask), .aes_random_bits(d_aes_random_bits),
    .aes_text_out(aes_text_out), .rsp_valid(d_rsp_valid), .rsp_ready(rsp_ready), .rsp_text(d_rsp_text)
  );

  // Stub core: ciphertext is only valid exactly LATENCY cycles after the start cycle.
  always @(posedge clk) begin
    if (rst) core_cnt <= 0;
    else if (aes_start) core_cnt <= 1;
    else if (core_cnt != 0 && core_cnt < 200) core_cnt <= core_cnt + 1;
  end
  assign aes_text_out = (core_cnt == LATENCY) ? CT : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Monitor: pop and compare on every response handshake.
  always begin
    @(negedge clk);
    #3;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected actual=%h required=no_response", rsp_text);
      end else begin
        check("rsp_text", rsp_text, exp_q.pop_front());
      end
      $display("rsp handshake text=%h", rsp_text);
    end
  end

  // Full transaction with rsp_ready high; seed_mode 0 none, 1 seed cycle before, 2 same cycle.
  task automatic run_txn(input logic [63:0] key, input logic [63:0] text, input int seed_mode, input logic [63:0] sd);
    int starts = 0, changes = 0, start_cyc = -100, last_chg = 0, cyc = 0;
    int bad_hold = 0, bad_space = 0, rsp_cyc = -1;
    logic [359:0] prev;
    logic [63:0] k0, t0, ki0, ti0;
    rsp_ready = 1'b1;
    if (seed_mode == 1) begin
      seed = sd; seed_load = 1'b1; step(); seed_load = 1'b0;
    end
    if (seed_mode == 2) begin
      seed = sd; seed_load = 1'b1;
    end
    req_key = key; req_text = text; req_valid = 1'b1;
    exp_q.push_back(CT);
    step();
    req_valid = 1'b0; seed_load = 1'b0;
    k0 = aes_k_mask; t0 = aes_t_mask; ki0 = aes_key_in; ti0 = aes_text_in;
    last_k = k0; last_t = t0;
    $display("req key=%h text=%h k_mask=%h t_mask=%h", key, text, k0, t0);
    check("req_ready_low_busy", 64'(req_ready), 64'd0);
    check("key_share_recombine", aes_key_in ^ aes_k_mask, key);
    check("text_share_recombine", aes_text_in ^ aes_t_mask, text);
    check("k_mask_nonzero", 64'(k0 != 64'h0), 64'd1);
    check("t_mask_nonzero", 64'(t0 != 64'h0), 64'd1);
    check("unmasked_key_in", d_aes_key_in, key);
    check("unmasked_text_in", d_aes_text_in, text);
    check("unmasked_masks_zero", d_aes_k_mask | d_aes_t_mask, 64'h0);
    prev = aes_random_bits;
    while (cyc < 80) begin
      if (aes_start) begin starts++; start_cyc = cyc; end
      if (aes_k_mask !== k0 || aes_t_mask !== t0 || aes_key_in !== ki0 || aes_text_in !== ti0) bad_hold++;
      if (aes_random_bits !== prev) begin
        if (changes < 10) rnd_log[changes] = aes_random_bits;
        if (changes == 0 ? (cyc != start_cyc + 1) : (cyc - last_chg != 4)) bad_space++;
        changes++;
        last_chg = cyc;
        prev = aes_random_bits;
      end
      if (rsp_valid) begin rsp_cyc = cyc; break; end
      step();
      cyc++;
    end
    check("start_pulse_count", 64'(starts), 64'd1);
    check("random_refresh_count", 64'(changes), 64'd10);
    check("random_refresh_spacing", 64'(bad_space), 64'd0);
    check("shares_constant", 64'(bad_hold), 64'd0);
    check("rsp_latency", 64'(rsp_cyc), 64'(start_cyc + LATENCY + 1));
    step();
    check("idle_req_ready", 64'(req_ready), 64'd1);
    check("idle_rsp_valid", 64'(rsp_valid), 64'd0);
    check("idle_shares_cleared", aes_key_in | aes_k_mask | aes_text_in | aes_t_mask, 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad, n;
    bit found;
    // Reset state.
    rst = 1'b1;
    repeat (3) step();
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_start_rsp", 64'({aes_start, rsp_valid}), 64'd0);
    check("rst_shares", aes_key_in | aes_k_mask | aes_text_in | aes_t_mask | rsp_text, 64'h0);
    check("rst_random", 64'(aes_random_bits != '0), 64'd0);
    rst = 1'b0;
    step();

    // First request from the default seed: hand-computed first LFSR step of lanes 0 and 1.
    run_txn(K1, 64'h0, 0, 64'h0);
    check("default_seed_k_mask", last_k, 64'hD800_0000_0000_0000);
    check("default_seed_t_mask", last_t, 64'h4F1B_BCDC_BFA5_3E0A);

    // Backpressure: response held, new request ignored until IDLE.
    rsp_ready = 1'b0;
    req_key = K2; req_text = T2; req_valid = 1'b1;
    exp_q.push_back(CT);
    step();
    req_valid = 1'b0;
    found = 1'b0; n = 0;
    while (!found && n < 80) begin
      if (rsp_valid) found = 1'b1;
      else begin step(); n++; end
    end
    check("hold_rsp_arrived", 64'(found), 64'd1);
    req_key = K3; req_text = T3; req_valid = 1'b1;
    bad = 0;
    repeat (20) begin
      step();
      if (rsp_valid !== 1'b1 || rsp_text !== CT || req_ready !== 1'b0 || aes_start !== 1'b0) bad++;
    end
    check("hold_20_cycles", 64'(bad), 64'd0);
    check("held_rsp_text", rsp_text, CT);
    rsp_ready = 1'b1;
    exp_q.push_back(CT);
    step();
    check("reidle_req_ready", 64'(req_ready), 64'd1);
    check("reidle_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reidle_key_cleared", aes_key_in, 64'h0);
    step();
    req_valid = 1'b0;
    check("late_req_accepted", 64'(req_ready), 64'd0);
    check("late_req_key_share", aes_key_in ^ aes_k_mask, K3);
    check("late_req_text_share", aes_text_in ^ aes_t_mask, T3);
    found = 1'b0; n = 0;
    while (!found && n < 80) begin
      if (rsp_valid) found = 1'b1;
      else begin step(); n++; end
    end
    check("late_rsp_arrived", 64'(found), 64'd1);
    step();

    // Reset in the middle of RUN at cnt=15.
    req_key = K1; req_text = T2; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    found = 1'b0; n = 0;
    while (!found && n < 20) begin
      if (aes_start) found = 1'b1;
      else begin step(); n++; end
    end
    check("midrst_start_seen", 64'(found), 64'd1);
    repeat (16) step();
    rst = 1'b1;
    step();
    check("midrst_req_ready", 64'(req_ready), 64'd1);
    check("midrst_start_rsp", 64'({aes_start, rsp_valid}), 64'd0);
    check("midrst_shares", aes_key_in | aes_k_mask | aes_text_in | aes_t_mask | rsp_text, 64'h0);
    check("midrst_random", 64'(aes_random_bits != '0), 64'd0);
    rst = 1'b0;
    bad = 0;
    repeat (60) begin
      step();
      if (rsp_valid || aes_start) bad++;
    end
    check("midrst_no_response", 64'(bad), 64'd0);

    // Determinism: same seed twice, second time loaded in the request cycle.
    run_txn(K1, 64'h0, 1, 64'hA5A5);
    check("seed_a5a5_k_mask", last_k, 64'hD800_0000_0000_52D2);
    check("seed_a5a5_t_mask", last_t, 64'h4F1B_BCDC_BFA5_6CD8);
    ref_t = last_t;
    for (int i = 0; i < 10; i++) ref_log[i] = rnd_log[i];
    run_txn(K1, 64'h0, 2, 64'hA5A5);
    check("seed_same_cycle_k_mask", last_k, 64'hD800_0000_0000_52D2);
    check("seed_repeat_t_mask", last_t, ref_t);
    bad = 0;
    for (int i = 0; i < 10; i++) if (rnd_log[i] !== ref_log[i]) bad++;
    check("seed_repeat_random_seq", 64'(bad), 64'd0);

    repeat (3) step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
